// File: rtl/udma_tdm_rx.sv
// udma_tdm_rx: TDM serial receiver with a show-ahead output FIFO.
//
// Pad sck/ws/sd are resynchronised into sys_clk_i. Each rising sck edge
// ("tick") carries one serial bit. A ws 0->1 between ticks marks frame
// start; that tick holds bit 0 of slot 0. Words from slots whose mask bit
// is set are pushed into the FIFO on the last bit of their slot.
//
// Ports
//   sys_clk_i, rst_i           clock, asynchronous active-high reset
//   cfg_en_i                   enable; low idles the receiver and flushes the FIFO
//   cfg_slot_mask_i            per-slot capture enable
//   cfg_word_bits_i            valid bits per slot (0 or >SLOT_BITS = SLOT_BITS)
//   cfg_lsb_first_i            1 = first serial bit is word bit 0
//   pad_sck_i/pad_ws_i/pad_sd_i asynchronous serial pads
//   data_rx_o, data_rx_slot_o  FIFO head word (right-aligned) and slot index
//   data_rx_valid_o/ready_i    head valid / consumer ready (pop when both high)
//   evt_overflow_o             pulse: word dropped because the FIFO was full
//   evt_frame_err_o            pulse: misplaced or missing frame start
//   dbg_state                  FSM state: 0 IDLE, 1 SYNC, 2 RUN
//
// Handshake: a word leaves the FIFO on every rising clock edge where
// data_rx_valid_o and data_rx_ready_i are both high; valid never depends
// on ready, and the head stays stable until it is popped.
module udma_tdm_rx #(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int WB_W      = $clog2(SLOT_BITS) + 1,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [NUM_SLOTS-1:0] cfg_slot_mask_i,
  input  logic [WB_W-1:0]      cfg_word_bits_i,
  input  logic                 cfg_lsb_first_i,
  input  logic                 pad_sck_i,
  input  logic                 pad_ws_i,
  input  logic                 pad_sd_i,
  output logic [SLOT_BITS-1:0] data_rx_o,
  output logic [SLOT_W-1:0]    data_rx_slot_o,
  output logic                 data_rx_valid_o,
  input  logic                 data_rx_ready_i,
  output logic                 evt_overflow_o,
  output logic                 evt_frame_err_o,
  output logic [1:0]           dbg_state
);

  localparam int BIT_W   = $clog2(SLOT_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = SLOT_W + SLOT_BITS;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [AW:0]       DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2} state_t;

  state_t state, state_nxt;

  // ---------------- pad synchronisers and edge detect ----------------
  logic [1:0] sck_sync, ws_sync, sd_sync;
  logic       sck_d, ws_prev;
  logic       tick, fs, sd;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], pad_sck_i};
      ws_sync  <= {ws_sync[0], pad_ws_i};
      sd_sync  <= {sd_sync[0], pad_sd_i};
      sck_d    <= sck_sync[1];
      // ws is only meaningful at ticks; keep the last sampled value so a
      // frame start is a rise between two consecutive ticks.
      if (tick) ws_prev <= ws_sync[1];
    end
  end

  assign tick = sck_sync[1] & ~sck_d;
  assign fs   = tick & ws_sync[1] & ~ws_prev;
  assign sd   = sd_sync[1];

  // ---------------- FSM ----------------
  logic [BIT_W-1:0]  bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              at_origin, capture, restart, frame_err;

  assign at_origin = (bit_cnt == '0) && (slot_cnt == '0);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    restart   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: if (cfg_en_i) state_nxt = SYNC;
      SYNC: if (fs) begin
        state_nxt = RUN;
        capture   = 1'b1;
        restart   = 1'b1;
      end
      RUN: begin
        if (fs) begin
          capture   = 1'b1;
          restart   = 1'b1;
          frame_err = !at_origin;
        end else if (tick) begin
          // The counters sit at slot 0 bit 0 only when a new frame is due.
          if (at_origin) begin
            frame_err = 1'b1;
            state_nxt = SYNC;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_nxt = IDLE;
      capture   = 1'b0;
      restart   = 1'b0;
      frame_err = 1'b0;
    end
  end

  assign dbg_state = state;

  // ---------------- bit/slot datapath ----------------
  logic [WB_W-1:0]      eff_bits;
  logic [BIT_W-1:0]     cur_bit, bit_nxt;
  logic [SLOT_W-1:0]    cur_slot, slot_nxt;
  logic [SLOT_BITS-1:0] cap, cap_base, cap_nxt;
  logic                 push, pop, push_ok, full, empty;

  always_comb begin
    eff_bits = cfg_word_bits_i;
    if (cfg_word_bits_i == '0 || cfg_word_bits_i > WB_W'(SLOT_BITS))
      eff_bits = WB_W'(SLOT_BITS);
  end

  always_comb begin
    cur_bit  = restart ? '0 : bit_cnt;
    cur_slot = restart ? '0 : slot_cnt;
    // Bit 0 starts a fresh word, which also discards any partial slot.
    cap_base = (cur_bit == '0) ? '0 : cap;
    cap_nxt  = cap_base;
    if ({1'b0, cur_bit} < eff_bits) begin
      if (cfg_lsb_first_i) cap_nxt[cur_bit] = sd;
      else                 cap_nxt = {cap_base[SLOT_BITS-2:0], sd};
    end
    bit_nxt  = cur_bit + 1'b1;
    slot_nxt = cur_slot;
    if (cur_bit == LAST_BIT) begin
      bit_nxt  = '0;
      slot_nxt = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
    end
    push = capture && (cur_bit == LAST_BIT) && cfg_slot_mask_i[cur_slot];
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt         <= '0;
      slot_cnt        <= '0;
      cap             <= '0;
      evt_frame_err_o <= 1'b0;
      evt_overflow_o  <= 1'b0;
    end else begin
      evt_frame_err_o <= frame_err;
      evt_overflow_o  <= push && !push_ok;
      if (capture) begin
        bit_cnt  <= bit_nxt;
        slot_cnt <= slot_nxt;
        cap      <= cap_nxt;
      end else if (state_nxt != RUN) begin
        bit_cnt  <= '0;
        slot_cnt <= '0;
        cap      <= '0;
      end
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = !empty && data_rx_ready_i && cfg_en_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge sys_clk_i) begin
    if (push_ok) mem[wr_ptr] <= {cur_slot, cap_nxt};
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!cfg_en_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_rx_valid_o = !empty;
  assign {data_rx_slot_o, data_rx_o} = empty ? '0 : mem[rd_ptr];

endmodule
